// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions used by the sequential divider.
// Holds the FSM encoding, the all-ones quotient constant and the counter sizing.
package alu_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_FIN  = 2'd2
    } div_state_t;

    localparam int DIV_MAX_WIDTH = 128;

    localparam logic [DIV_MAX_WIDTH-1:0] DIV_ALL_ONES = '1;

    function automatic int div_cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/my_div_seq_if.sv
// Start/busy/done handshake and operand/result bundle for the divider.
// The requester uses master, the divider uses slave.
interface my_div_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/my_sub_step.sv
// Combinational (WIDTH+1)-bit trial subtract a - b, returning diff and borrow.
// Ripple of full-adder cells adding ~b with carry-in 1.
module my_sub_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    output logic [WIDTH:0] diff,
    output logic           borrow
);

    logic [WIDTH+1:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i <= WIDTH; i++) begin : g_bit
        logic nb;
        logic p;
        assign nb           = ~b[i];
        assign p            = a[i] ^ nb;
        assign diff[i]      = p ^ carry[i];
        assign carry[i + 1] = (a[i] & nb) | (carry[i] & p);
    end

    // No carry out of a + ~b + 1 means a < b.
    assign borrow = ~carry[WIDTH + 1];

endmodule

// File: rtl/my_div_seq.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Start/busy/done handshake; divide-by-zero short-circuits to FIN.
module my_div_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         reset,
    my_div_seq_if.slave bus
);

    localparam int CW = div_cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ALL_ONES = DIV_ALL_ONES[WIDTH-1:0];

    div_state_t       state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem_acc;
    logic [WIDTH-1:0] q_acc;
    logic [WIDTH-1:0] dvs;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] q_next;
    logic             unused_diff_msb;

    // Shifted remainder picks up the dividend MSB still held in q_acc.
    assign shifted = {rem_acc, q_acc[WIDTH-1]};

    my_sub_step #(
        .WIDTH (WIDTH)
    ) u_sub (
        .a      (shifted),
        .b      ({1'b0, dvs}),
        .diff   (diff),
        .borrow (borrow)
    );

    assign rem_next        = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign q_next          = {q_acc[WIDTH-2:0], ~borrow};
    assign unused_diff_msb = diff[WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= DIV_IDLE;
            count           <= '0;
            rem_acc         <= '0;
            q_acc           <= '0;
            dvs             <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.quotient    <= '0;
            bus.remainder   <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                DIV_IDLE: begin
                    if (bus.start) begin
                        if (bus.divisor == '0) begin
                            bus.quotient    <= ALL_ONES;
                            bus.remainder   <= bus.dividend;
                            bus.div_by_zero <= 1'b1;
                            bus.done        <= 1'b1;
                            state           <= DIV_FIN;
                        end else begin
                            dvs             <= bus.divisor;
                            rem_acc         <= '0;
                            q_acc           <= bus.dividend;
                            count           <= '0;
                            bus.div_by_zero <= 1'b0;
                            bus.busy        <= 1'b1;
                            state           <= DIV_RUN;
                        end
                    end
                end
                DIV_RUN: begin
                    rem_acc <= rem_next;
                    q_acc   <= q_next;
                    count   <= count + 1'b1;
                    if (count == LAST) begin
                        bus.quotient  <= q_next;
                        bus.remainder <= rem_next;
                        bus.busy      <= 1'b0;
                        bus.done      <= 1'b1;
                        state         <= DIV_FIN;
                    end
                end
                DIV_FIN: begin
                    state <= DIV_IDLE;
                end
                default: begin
                    state <= DIV_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_my_div_seq.sv
// Self-checking bench for my_div_seq: cycle-level expectation model plus directed cases.
// Expected timing and results come from plain division on the captured operands.
module tb_my_div_seq;

    localparam int W = 32;

    logic clk;
    logic reset;
    int   cyc;
    int   n_tests;
    int   n_fail;

    my_div_seq_if #(.WIDTH(W)) bus ();

    my_div_seq #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expectation model state
    int           acc_cyc;
    int           done_cyc;
    logic [W-1:0] pend_a;
    logic [W-1:0] pend_b;
    logic [W-1:0] pend_q;
    logic [W-1:0] pend_r;
    logic         pend_z;
    logic [W-1:0] cur_q;
    logic [W-1:0] cur_r;
    logic         cur_z;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_model(input logic [W-1:0] a, input logic [W-1:0] b,
                             input int acc);
        acc_cyc = acc;
        pend_a  = a;
        pend_b  = b;
        if (b == 0) begin
            done_cyc = acc;
            pend_q   = '1;
            pend_r   = a;
            pend_z   = 1'b1;
        end else begin
            done_cyc = acc + W;
            pend_q   = a / b;
            pend_r   = a % b;
            pend_z   = 1'b0;
        end
    endtask

    // Called with the divider idle; the next rising edge accepts.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        set_model(a, b, cyc + 1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        launch(a, b);
        tick();
        bus.start = 1'b0;
        while (cyc <= done_cyc) tick();
    endtask

    // Per-cycle compare against the model
    initial begin
        forever begin
            @(negedge clk);
            if (cyc == acc_cyc && !pend_z) cur_z = 1'b0;
            if (cyc == done_cyc) begin
                cur_q = pend_q;
                cur_r = pend_r;
                cur_z = pend_z;
            end
            chk("busy", bus.busy, (cyc >= acc_cyc) && (cyc < done_cyc));
            chk("done", bus.done, cyc == done_cyc);
            chk("quotient", bus.quotient, cur_q);
            chk("remainder", bus.remainder, cur_r);
            chk("div_by_zero", bus.div_by_zero, cur_z);
            if (cyc == done_cyc && !pend_z) begin
                chk("invariant", 64'(bus.quotient) * 64'(pend_b)
                    + 64'(bus.remainder), 64'(pend_a));
                chk("rem_lt_div", bus.remainder < pend_b, 1);
            end
        end
    end

    logic [W-1:0] corners [4];
    int           busy_n;
    int           done_at;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        acc_cyc      = -100;
        done_cyc     = -100;
        pend_a       = '0;
        pend_b       = '0;
        pend_q       = '0;
        pend_r       = '0;
        pend_z       = 1'b0;
        cur_q        = '0;
        cur_r        = '0;
        cur_z        = 1'b0;
        corners[0]   = 32'h0;
        corners[1]   = 32'h1;
        corners[2]   = 32'h8000_0000;
        corners[3]   = 32'hFFFF_FFFF;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_q", bus.quotient, 0);
        chk("rst_r", bus.remainder, 0);
        chk("rst_dbz", bus.div_by_zero, 0);
        reset = 1'b0;
        tick();

        // 1: 100/7 with latency measured from the pins
        launch(100, 7);
        tick();
        bus.start = 1'b0;
        busy_n  = 0;
        done_at = -1;
        for (int k = 0; k < 40 && done_at < 0; k++) begin
            @(negedge clk);
            if (bus.busy) busy_n++;
            if (bus.done) done_at = k;
            tick();
        end
        chk("t1_busy_cycles", busy_n, 32);
        chk("t1_done_edges", done_at + 1, 33);
        chk("t1_q", bus.quotient, 14);
        chk("t1_r", bus.remainder, 2);
        chk("t1_dbz", bus.div_by_zero, 0);

        // 2: max/1, then 5/9 taken back-to-back with start held
        launch(32'hFFFF_FFFF, 1);
        tick();
        bus.dividend = 5;
        bus.divisor  = 9;
        while (cyc < done_cyc + 1) tick();
        chk("t2_q_max", bus.quotient, 32'hFFFF_FFFF);
        chk("t2_r_max", bus.remainder, 0);
        set_model(5, 9, cyc + 1);
        tick();
        bus.start = 1'b0;
        while (cyc <= done_cyc) tick();
        chk("t2_q_small", bus.quotient, 0);
        chk("t2_r_small", bus.remainder, 5);

        // 3: divide by zero, then a valid divide clears the flag
        run_op(1234, 0);
        chk("t3_q", bus.quotient, 32'hFFFF_FFFF);
        chk("t3_r", bus.remainder, 1234);
        chk("t3_dbz", bus.div_by_zero, 1);
        run_op(10, 3);
        chk("t3_dbz_clr", bus.div_by_zero, 0);
        chk("t3_q2", bus.quotient, 3);
        chk("t3_r2", bus.remainder, 1);

        // 4: start pulsed mid-run is ignored
        launch(1000, 3);
        tick();
        bus.start = 1'b0;
        while (cyc < acc_cyc + 10) tick();
        bus.start    = 1'b1;
        bus.dividend = 50;
        bus.divisor  = 5;
        tick();
        bus.start = 1'b0;
        while (cyc <= done_cyc) tick();
        chk("t4_q", bus.quotient, 333);
        chk("t4_r", bus.remainder, 1);
        repeat (5) tick();
        chk("t4_q_hold", bus.quotient, 333);
        chk("t4_r_hold", bus.remainder, 1);

        // 5: reset mid-run aborts without done
        launch(1000, 7);
        tick();
        bus.start = 1'b0;
        while (cyc < acc_cyc + 15) tick();
        reset    = 1'b1;
        acc_cyc  = -100;
        done_cyc = -100;
        cur_q    = '0;
        cur_r    = '0;
        cur_z    = 1'b0;
        #1;
        chk("t5_q_async", bus.quotient, 0);
        chk("t5_r_async", bus.remainder, 0);
        chk("t5_busy_async", bus.busy, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        run_op(81, 9);
        chk("t5_q", bus.quotient, 9);
        chk("t5_r", bus.remainder, 0);

        // 6: corner pairs, then random operands
        for (int i = 0; i < 150; i++) begin
            if (i < 16) begin
                ra = corners[i / 4];
                rb = corners[i % 4];
            end else if (i % 5 == 0) begin
                rb = $urandom;
                ra = $urandom_range(0, 1000);
            end else begin
                ra = $urandom;
                rb = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
            end
            run_op(ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
